pulse_gen_lehr: RTL and testbench

Programmable strobe generator: the driving end of the enable interface of our 4-bit up-counter. It produces single-cycle `enable_out` strobes at a programmed interval, either once or periodically, and reports run status and completion. One instance sits ahead of each counter and drives that counter's `enable` input directly.

---
 rtl/pulse_gen_lehr_if.sv | 25 ++
 rtl/pulse_gen_lehr.sv | 85 ++++++++
 tb/tb_pulse_gen_lehr.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_gen_lehr_if.sv
// Command/status bundle between a strobe-generator client and pulse_gen_lehr.
// The generator sits on the slave side: it takes commands and reports status.
interface pulse_gen_lehr_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic             stop;
   logic             periodic;
   logic [WIDTH-1:0] period;
   logic             enable_out;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] remaining;
   logic [WIDTH-1:0] strobe_cnt;

   modport master (
      output start, stop, periodic, period,
      input  enable_out, busy, done, remaining, strobe_cnt
   );

   modport slave (
      input  start, stop, periodic, period,
      output enable_out, busy, done, remaining, strobe_cnt
   );
endinterface

// File: rtl/pulse_gen_lehr.sv
// Programmable strobe generator: one-cycle enable strobes every P+1 cycles,
// either once (with a done pulse) or periodically, with a running strobe count.
module pulse_gen_lehr #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   pulse_gen_lehr_if.slave  bus
);

   typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_cnt;
   logic [WIDTH-1:0] r_period_q;
   logic             r_mode_q;
   logic             r_done_q;
   logic [WIDTH-1:0] r_strobe_cnt;
   logic             w_strobe;

   // Strobe is decoded from registers only, never from the inputs.
   assign w_strobe = (r_state == S_RUN) && (r_cnt == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (bus.stop) begin
         w_state_nxt = S_IDLE;
      end else if (bus.start) begin
         w_state_nxt = S_RUN;
      end else if (w_strobe && !r_mode_q) begin
         w_state_nxt = S_IDLE;
      end
   end

   always_comb begin
      bus.enable_out = w_strobe;
      bus.busy       = (r_state == S_RUN);
      bus.done       = r_done_q;
      bus.remaining  = r_cnt;
      bus.strobe_cnt = r_strobe_cnt;
   end

   // A strobe that coincides with start still counts; stop discards it.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt        <= '0;
         r_period_q   <= '0;
         r_mode_q     <= 1'b0;
         r_done_q     <= 1'b0;
         r_strobe_cnt <= '0;
      end else begin
         r_done_q <= 1'b0;
         if (bus.stop) begin
            r_cnt <= '0;
         end else begin
            if (w_strobe) begin
               r_strobe_cnt <= r_strobe_cnt + 1'b1;
            end
            if (bus.start) begin
               r_period_q <= bus.period;
               r_mode_q   <= bus.periodic;
               r_cnt      <= bus.period;
            end else if (r_state == S_RUN) begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - 1'b1;
               end else if (r_mode_q) begin
                  r_cnt <= r_period_q;
               end else begin
                  r_done_q <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_pulse_gen_lehr.sv
// Directed bench for pulse_gen_lehr with an elapsed-time reference model
// checked every cycle, plus literal expectations from the timing rules.
module tb_pulse_gen_lehr;
   localparam int W = 4;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   pulse_gen_lehr_if #(.WIDTH(W)) bus ();
   pulse_gen_lehr #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

   int n_chk  = 0;
   int n_pass = 0;
   bit chk_en = 1'b0;

   // Model: a run is described by its start edge age, interval and mode.
   bit m_act = 1'b0;
   int m_e   = 0;
   int m_p   = 0;
   bit m_per = 1'b0;
   int m_sc  = 0;

   function automatic void model_out(output bit en, output bit busy,
                                     output bit done, output int rem);
      en = 0; busy = 0; done = 0; rem = 0;
      if (m_act) begin
         if (m_per) begin
            rem  = m_p - (m_e % (m_p + 1));
            en   = (rem == 0);
            busy = 1;
         end else if (m_e <= m_p) begin
            rem  = m_p - m_e;
            en   = (m_e == m_p);
            busy = 1;
         end else if (m_e == m_p + 1) begin
            done = 1;
         end
      end
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
   endtask

   initial begin
      bit en, bsy, dn;
      int rem;
      forever begin
         @(posedge clk);
         model_out(en, bsy, dn, rem);
         if (reset) begin
            m_act = 0;
            m_sc  = 0;
         end else if (bus.stop) begin
            m_act = 0;
         end else begin
            if (en) m_sc = (m_sc + 1) % (1 << W);
            if (bus.start) begin
               m_act = 1;
               m_e   = 0;
               m_p   = int'(bus.period);
               m_per = bus.periodic;
            end else if (m_act) begin
               m_e++;
            end
         end
      end
   end

   initial begin
      bit en, bsy, dn;
      int rem;
      forever begin
         @(negedge clk);
         if (chk_en) begin
            model_out(en, bsy, dn, rem);
            chk("model_enable_out", int'(bus.enable_out), int'(en));
            chk("model_busy", int'(bus.busy), int'(bsy));
            chk("model_done", int'(bus.done), int'(dn));
            chk("model_remaining", int'(bus.remaining), rem);
            chk("model_strobe_cnt", int'(bus.strobe_cnt), m_sc);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic go(input int p, input bit per);
      bus.period   = p[W-1:0];
      bus.periodic = per;
      bus.start    = 1'b1;
      cyc();
      bus.start    = 1'b0;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
   endtask

   task automatic do_stop();
      bus.stop = 1'b1;
      cyc();
      bus.stop = 1'b0;
   endtask

   initial begin
      int n_en, n_dn;
      bus.start = 0; bus.stop = 0; bus.periodic = 0; bus.period = '0;
      cyc(); cyc();
      reset  = 1'b0;
      chk_en = 1'b1;
      chk("rst_enable_out", int'(bus.enable_out), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_done", int'(bus.done), 0);
      chk("rst_remaining", int'(bus.remaining), 0);
      chk("rst_strobe_cnt", int'(bus.strobe_cnt), 0);

      // One-shot P=3
      go(3, 0);
      chk("os_rem_k", int'(bus.remaining), 3);
      chk("os_busy_k", int'(bus.busy), 1);
      cyc(); chk("os_rem_k1", int'(bus.remaining), 2);
      cyc(); chk("os_rem_k2", int'(bus.remaining), 1);
      chk("os_en_k2", int'(bus.enable_out), 0);
      cyc(); chk("os_rem_k3", int'(bus.remaining), 0);
      chk("os_en_k3", int'(bus.enable_out), 1);
      chk("os_done_k3", int'(bus.done), 0);
      cyc(); chk("os_done_k4", int'(bus.done), 1);
      chk("os_busy_k4", int'(bus.busy), 0);
      chk("os_en_k4", int'(bus.enable_out), 0);
      chk("os_sc_k4", int'(bus.strobe_cnt), 1);
      cyc(); chk("os_done_k5", int'(bus.done), 0);

      // Periodic P=2 for 12 cycles
      pulse_reset();
      go(2, 1);
      n_en = 0; n_dn = 0;
      for (int i = 0; i < 12; i++) begin
         n_en += int'(bus.enable_out);
         n_dn += int'(bus.done);
         if (i == 2 || i == 5 || i == 8 || i == 11) chk("per2_strobe", int'(bus.enable_out), 1);
         cyc();
      end
      chk("per2_strobes", n_en, 4);
      chk("per2_done", n_dn, 0);
      chk("per2_sc", int'(bus.strobe_cnt), 4);
      do_stop();

      // Periodic P=0 for 20 cycles, strobe count wraps
      pulse_reset();
      go(0, 1);
      n_en = 0;
      for (int i = 0; i < 20; i++) begin
         n_en += int'(bus.enable_out);
         if (i == 15) chk("per0_sc15", int'(bus.strobe_cnt), 15);
         if (i == 16) chk("per0_sc_wrap", int'(bus.strobe_cnt), 0);
         cyc();
      end
      chk("per0_strobes", n_en, 20);
      do_stop();

      // Start held high: P=0 strobes every cycle, P=2 never
      pulse_reset();
      bus.period = 4'd0; bus.periodic = 1'b0; bus.start = 1'b1;
      cyc(); cyc(); cyc();
      chk("hold0_en", int'(bus.enable_out), 1);
      chk("hold0_sc", int'(bus.strobe_cnt), 2);
      bus.period = 4'd2;
      cyc();
      chk("hold2_sc", int'(bus.strobe_cnt), 3);
      cyc();
      chk("hold2_en", int'(bus.enable_out), 0);
      chk("hold2_rem", int'(bus.remaining), 2);
      bus.start = 1'b0;
      do_stop();

      // Start and stop together while idle
      bus.period = 4'd3; bus.start = 1'b1; bus.stop = 1'b1;
      cyc();
      bus.start = 1'b0; bus.stop = 1'b0;
      chk("ss_busy", int'(bus.busy), 0);
      chk("ss_rem", int'(bus.remaining), 0);

      // Stop during a P=5 run at remaining=2
      go(5, 0);
      cyc(); cyc(); cyc();
      chk("stop_rem_before", int'(bus.remaining), 2);
      do_stop();
      chk("stop_busy", int'(bus.busy), 0);
      chk("stop_rem", int'(bus.remaining), 0);
      chk("stop_en", int'(bus.enable_out), 0);
      n_en = 0; n_dn = 0;
      for (int i = 0; i < 6; i++) begin
         n_en += int'(bus.enable_out);
         n_dn += int'(bus.done) + int'(bus.busy);
         cyc();
      end
      chk("stop_quiet_en", n_en, 0);
      chk("stop_quiet_done", n_dn, 0);

      // Restart one-shot P=4 at remaining=1 into periodic P=6
      go(4, 0);
      cyc(); cyc(); cyc();
      chk("rs_rem_before", int'(bus.remaining), 1);
      go(6, 1);
      bus.period = 4'd9; bus.periodic = 1'b0;
      chk("rs_rem", int'(bus.remaining), 6);
      chk("rs_busy", int'(bus.busy), 1);
      n_en = 0; n_dn = 0;
      for (int i = 0; i < 15; i++) begin
         n_en += int'(bus.enable_out);
         n_dn += int'(bus.done);
         if (i == 6 || i == 13) chk("rs_strobe", int'(bus.enable_out), 1);
         cyc();
      end
      chk("rs_strobes", n_en, 2);
      chk("rs_done", n_dn, 0);
      do_stop();

      // Reset in the strobe cycle of a one-shot
      go(2, 0);
      cyc(); cyc();
      chk("rst_strobe_en", int'(bus.enable_out), 1);
      pulse_reset();
      chk("rst_mid_en", int'(bus.enable_out), 0);
      chk("rst_mid_done", int'(bus.done), 0);
      chk("rst_mid_sc", int'(bus.strobe_cnt), 0);
      cyc();
      chk("rst_after_done", int'(bus.done), 0);
      chk("rst_after_busy", int'(bus.busy), 0);
      cyc();

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
